// File: rtl/icache_assoc_if.sv
// icache_assoc_if: bundle of fetch-side, data-hazard and memory-side signals for icache_assoc.
//   slave  : cache view (fetch/mem inputs in, ihit/imemload/iREN/iaddr out)
//   master : environment view (datapath + memory arbiter), directions reversed
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative read-only instruction cache, multi-word blocks, LRU replacement,
// single-cycle flush. Hits are combinational; a miss fetches the whole block one word per
// memory handshake and then returns to idle.
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   bus       : icache_assoc_if.slave (fetch request/response, dmem gating, flush, memory channel)
module icache_assoc #(
  parameter int unsigned NSETS    = 8,
  parameter int unsigned NWAYS    = 2,
  parameter int unsigned BLKWORDS = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_assoc_if.slave bus
);
  localparam int unsigned WOFF_W = $clog2(BLKWORDS);
  localparam int unsigned IDX_W  = $clog2(NSETS);
  localparam int unsigned TAG_W  = 30 - WOFF_W - IDX_W;
  // Word counter keeps at least one bit so single-word blocks still elaborate.
  localparam int unsigned WCNT_W = (WOFF_W > 0) ? WOFF_W : 1;

  typedef enum logic {StIdle, StFill} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [TAG_W-1:0]    fill_tag_q;
  logic [IDX_W-1:0]    fill_idx_q;
  logic                fill_way_q;

  logic [NWAYS-1:0]    valid_q [NSETS];
  logic [NSETS-1:0]    lru_q;
  logic [TAG_W-1:0]    tag_arr [NSETS][NWAYS];
  logic [31:0]         data_arr [NSETS][NWAYS][BLKWORDS];

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [WCNT_W-1:0]   req_woff;
  logic                hit, hit_way, victim;
  logic                no_dhaz, ihit, miss_start, word_done, last_word;
  logic                unused_bits;

  assign req_tag     = bus.imemaddr[31 -: TAG_W];
  assign req_idx     = bus.imemaddr[2+WOFF_W +: IDX_W];
  assign req_woff    = (WOFF_W > 0) ? bus.imemaddr[2 +: WCNT_W] : '0;
  assign unused_bits = ^bus.imemaddr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Prefer an empty way (way 0 first) before evicting the LRU way.
  always_comb begin
    victim = 1'b0;
    if (NWAYS == 2 && valid_q[req_idx][0]) begin
      victim = valid_q[req_idx][NWAYS-1] ? lru_q[req_idx] : 1'b1;
    end
  end

  assign no_dhaz    = !bus.dmemREN && !bus.dmemWEN && !bus.flush;
  assign ihit       = bus.imemREN && hit && (state_q == StIdle) && no_dhaz;
  assign miss_start = bus.imemREN && !hit && (state_q == StIdle) && no_dhaz;
  assign word_done  = (state_q == StFill) && !bus.iwait;
  assign last_word  = word_done && (wcnt_q == WCNT_W'(BLKWORDS - 1));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: if (miss_start) state_d = StFill;
      StFill: begin
        if (word_done) wcnt_d = wcnt_q + 1'b1;
        // Flush aborts the fill and wins over completion.
        if (last_word || bus.flush) begin
          state_d = StIdle;
          wcnt_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ihit     = ihit;
  assign bus.imemload = ihit ? data_arr[req_idx][hit_way][req_woff] : 32'h0;
  assign bus.iREN     = (state_q == StFill);
  assign bus.iaddr    = (state_q == StFill) ?
                        ({fill_tag_q, fill_idx_q, {(WOFF_W+2){1'b0}}} | (32'(wcnt_q) << 2)) :
                        32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      fill_way_q <= 1'b0;
      lru_q      <= '0;
      for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (miss_start) begin
        fill_tag_q                <= req_tag;
        fill_idx_q                <= req_idx;
        fill_way_q                <= victim;
        valid_q[req_idx][victim]  <= 1'b0;
      end
      if (ihit && NWAYS == 2) lru_q[req_idx] <= ~hit_way;
      if (last_word) begin
        valid_q[fill_idx_q][fill_way_q] <= 1'b1;
        if (NWAYS == 2) lru_q[fill_idx_q] <= ~fill_way_q;
      end
      if (bus.flush) begin
        for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
      end
    end
  end

  // Payload storage needs no reset; valid bits guard it.
  always_ff @(posedge CLK) begin
    if (word_done) data_arr[fill_idx_q][fill_way_q][wcnt_q] <= bus.iload;
    if (last_word) tag_arr[fill_idx_q][fill_way_q] <= fill_tag_q;
  end
endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;
  logic CLK;
  logic nRST;
  icache_assoc_if bus ();

  icache_assoc #(.NSETS(8), .NWAYS(2), .BLKWORDS(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [31:0] hit_q  [$];
  logic [31:0] addr_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every hit and every memory handshake must match the next queued expectation.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (bus.ihit === 1'b1) begin
        total++;
        if (hit_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_hit actual=%h required=no_hit", bus.imemload);
        end else begin
          logic [31:0] e;
          e = hit_q.pop_front();
          total--;
          check("hit_data", bus.imemload, e);
        end
      end
      if (bus.iREN === 1'b1 && bus.iwait === 1'b0) begin
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_fetch actual=%h required=none", bus.iaddr);
        end else begin
          logic [31:0] e;
          e = addr_q.pop_front();
          total--;
          check("fill_addr", bus.iaddr, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    #1 check("miss_before_fill", 32'(bus.ihit), 32'h0);
    step();
    bus.iwait = 1'b0;
    bus.iload = w0;
    addr_q.push_back(a);
    step();
    bus.iload = w1;
    addr_q.push_back(a + 32'h4);
    step();
    bus.iwait   = 1'b1;
    bus.imemREN = 1'b0;
  endtask

  task automatic req_hit(input logic [31:0] a, input logic [31:0] d);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    hit_q.push_back(d);
    step();
    bus.imemREN = 1'b0;
  endtask

  // Request is dropped before the edge so the miss does not start a fill.
  task automatic expect_miss(input string nm, input logic [31:0] a);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    #1 check(nm, 32'(bus.ihit), 32'h0);
    bus.imemREN = 1'b0;
    step();
  endtask

  initial begin
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.dmemREN  = 1'b0;
    bus.dmemWEN  = 1'b0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    @(posedge CLK);
    #1;
    check("rst_ihit", 32'(bus.ihit), 32'h0);
    check("rst_imemload", bus.imemload, 32'h0);
    check("rst_iREN", 32'(bus.iREN), 32'h0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    nRST = 1'b1;
    step();

    // Cold miss, fill, hit
    miss_fill(32'h40, 32'hAAAA0001, 32'hAAAA0002);
    req_hit(32'h40, 32'hAAAA0001);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h44;
    hit_q.push_back(32'hAAAA0002);
    #1 check("hit_iREN_low", 32'(bus.iREN), 32'h0);
    step();
    bus.imemREN = 1'b0;

    // LRU eviction: 0x40 way0, 0x80 way1, touch 0x40, 0xC0 evicts 0x80
    miss_fill(32'h80, 32'hBBBB0001, 32'hBBBB0002);
    req_hit(32'h40, 32'hAAAA0001);
    miss_fill(32'hC0, 32'hCCCC0001, 32'hCCCC0002);
    req_hit(32'h40, 32'hAAAA0001);
    req_hit(32'hC4, 32'hCCCC0002);
    expect_miss("lru_evicted_80", 32'h80);

    // dmem gating
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.dmemREN  = 1'b1;
    #1;
    check("gate_ihit", 32'(bus.ihit), 32'h0);
    check("gate_imemload", bus.imemload, 32'h0);
    check("gate_iREN", 32'(bus.iREN), 32'h0);
    step();
    check("gate_no_fill", 32'(bus.iREN), 32'h0);
    bus.dmemREN = 1'b0;
    hit_q.push_back(32'hAAAA0001);
    #1 check("ungate_ihit", 32'(bus.ihit), 32'h1);
    step();
    bus.imemREN = 1'b0;

    // Address change mid-fill: 0x100 evicts LRU way (0xC0)
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h100;
    #1 check("mid_miss", 32'(bus.ihit), 32'h0);
    step();
    bus.iwait = 1'b0;
    bus.iload = 32'hDDDD0001;
    addr_q.push_back(32'h100);
    step();
    bus.imemaddr = 32'h200;
    bus.iload    = 32'hDDDD0002;
    addr_q.push_back(32'h104);
    step();
    bus.iwait = 1'b1;
    req_hit(32'h100, 32'hDDDD0001);
    req_hit(32'h104, 32'hDDDD0002);
    expect_miss("mid_200_miss", 32'h200);

    // Flush with 0x40 and 0x80 resident
    miss_fill(32'h80, 32'hBBBB0011, 32'hBBBB0012);
    miss_fill(32'h40, 32'hAAAA0011, 32'hAAAA0012);
    req_hit(32'h80, 32'hBBBB0011);
    req_hit(32'h44, 32'hAAAA0012);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.flush    = 1'b1;
    #1 check("flush_gates_hit", 32'(bus.ihit), 32'h0);
    step();
    bus.flush   = 1'b0;
    bus.imemREN = 1'b0;
    check("flush_no_fill", 32'(bus.iREN), 32'h0);
    expect_miss("flush_40_miss", 32'h40);
    expect_miss("flush_80_miss", 32'h80);

    // Flush during fill
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h100;
    step();
    bus.imemREN = 1'b0;
    check("ffill_iREN", 32'(bus.iREN), 32'h1);
    check("ffill_iaddr", bus.iaddr, 32'h100);
    bus.flush = 1'b1;
    #1 check("ffill_iREN_hold", 32'(bus.iREN), 32'h1);
    step();
    bus.flush = 1'b0;
    check("ffill_idle", 32'(bus.iREN), 32'h0);
    expect_miss("ffill_100_miss", 32'h100);

    // Reset mid-fill
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    step();
    bus.imemREN = 1'b0;
    check("rfill_iREN", 32'(bus.iREN), 32'h1);
    nRST = 1'b0;
    #1;
    check("rfill_iREN_drop", 32'(bus.iREN), 32'h0);
    check("rfill_iaddr_zero", bus.iaddr, 32'h0);
    #20 nRST = 1'b1;
    step();
    expect_miss("rfill_40_miss", 32'h40);

    step();
    check("hit_q_drained", 32'(hit_q.size()), 32'h0);
    check("addr_q_drained", 32'(addr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
